// File: rtl/game_timer_bank.sv
// game_timer_bank: bank of independent countdown timers for game logic.
// Each channel has a runtime reload value, one-shot or periodic mode, pause,
// a registered one-cycle expiry pulse and a saturating or wrapping event counter.
module game_timer_bank #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 32,
  parameter int EVT_W    = 8,
  parameter bit EVT_WRAP = 1'b0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_CH-1:0]       load,
  input  logic [CNT_W-1:0]        load_value,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       evt_clear,
  output logic [NUM_CH-1:0]       expire,
  output logic [NUM_CH-1:0]       active,
  output logic [NUM_CH*CNT_W-1:0] count_out,
  output logic [NUM_CH*EVT_W-1:0] evt_out
);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] reload_q;
    logic [EVT_W-1:0] evt_q;
    logic [EVT_W-1:0] evt_next;
    logic             active_q;
    logic             expire_q;
    logic             running;
    logic             at_one;
    logic             fire;

    // A channel only counts when armed and enabled; a load on the same edge
    // always wins, so it also cancels an expiry that would otherwise happen.
    assign running = active_q & enable[ch];
    assign at_one  = (count_q == CNT_W'(1));
    assign fire    = ~load[ch] & running & at_one;

    // Event counter increment, either sticking at all-ones or rolling over to 0.
    assign evt_next = ((evt_q == '1) && !EVT_WRAP) ? evt_q : evt_q + EVT_W'(1);

    // Countdown, reload, arming and expiry pulse: load, then count/expire, then hold.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        count_q  <= '0;
        reload_q <= '0;
        active_q <= 1'b0;
        expire_q <= 1'b0;
      end else if (load[ch]) begin
        reload_q <= load_value;
        count_q  <= load_value;
        active_q <= (load_value != '0);
        expire_q <= 1'b0;
      end else if (running) begin
        if (at_one) begin
          expire_q <= 1'b1;
          if (periodic[ch]) begin
            count_q <= reload_q;
          end else begin
            count_q  <= '0;
            active_q <= 1'b0;
          end
        end else begin
          count_q  <= count_q - CNT_W'(1);
          expire_q <= 1'b0;
        end
      end else begin
        expire_q <= 1'b0;
      end
    end

    // Event counter: an expiry coinciding with a clear still counts as one event.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        evt_q <= '0;
      end else if (fire) begin
        evt_q <= evt_clear[ch] ? EVT_W'(1) : evt_next;
      end else if (evt_clear[ch]) begin
        evt_q <= '0;
      end
    end

    assign expire[ch]                   = expire_q;
    assign active[ch]                   = active_q;
    assign count_out[ch*CNT_W +: CNT_W] = count_q;
    assign evt_out[ch*EVT_W +: EVT_W]   = evt_q;
  end

endmodule

// File: doc/game_timer_bank.md
Name: game_timer_bank

Overview:
- Parametrised bank of NUM_CH independent countdown timers for game logic: level timeouts, score tick generation and frame-rate events.
- Each channel has a runtime reload value, one-shot or periodic mode, pause, a one-cycle expiry pulse and a saturating or wrapping event counter (for example, score).
- Sits beside the game-state logic and is clocked from the 50 MHz system clock.

Parameters:
- NUM_CH, 2, number of independent timer channels (1..8).
- CNT_W, 32, countdown width; maximum period is 2^CNT_W-1 cycles.
- EVT_W, 8, width of each channel's event counter.
- EVT_WRAP, 0, event counter overflow: 0 = saturate at all-ones, 1 = wrap to 0.

Ports:
- clk  in  1  system clock, rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- load  in  NUM_CH  per-channel load strobe; loads load_value as reload and count.
- load_value  in  CNT_W  period in cycles, shared by all channels.
- periodic  in  NUM_CH  per-channel mode: 1 = auto-reload, 0 = one-shot.
- enable  in  NUM_CH  per-channel run/pause; low holds count.
- evt_clear  in  NUM_CH  per-channel event-counter clear.
- expire  out  NUM_CH  registered one-cycle pulse at expiry.
- active  out  NUM_CH  channel armed (count nonzero or periodic reload pending).
- count_out  out  NUM_CH*CNT_W  current counts; channel i occupies [i*CNT_W +: CNT_W].
- evt_out  out  NUM_CH*EVT_W  event counters; channel i occupies [i*EVT_W +: EVT_W].

Behaviour:
- Reset (resetn low, asynchronous): count, reload, evt, active and expire all 0 on every channel. Deassertion is sampled on clk; the first edge after release behaves normally.
- Per-channel priority each clock edge, highest first: load, then decrement/expire, then hold.
- Load, load[i]=1:
  - reload_i <= load_value, count_i <= load_value.
  - active_i <= (load_value != 0).
  - expire_i <= 0, even if the channel would have expired that cycle.
  - Load is accepted whether enable_i is high or low.
- Decrement, active_i & enable_i & count_i > 1: count_i <= count_i - 1, expire_i <= 0.
- Expiry, active_i & enable_i & count_i == 1:
  - expire_i <= 1 for exactly one cycle.
  - periodic_i=1: count_i <= reload_i, active stays 1.
  - periodic_i=0: count_i <= 0, active_i <= 0.
  - Mode is sampled at the expiry edge only; changing it mid-count has no other effect.
- Period: with enable held high, expire pulses occur every reload_i cycles exactly. The first pulse is asserted in the cycle reload_i edges after the load edge.
- Pause: enable_i low freezes count_i and active_i and forces expire_i <= 0. On resume, counting continues from the frozen value.
- Zero load: load_value=0 gives count 0 and active 0. The channel never expires until reloaded with a nonzero value.
- Inactive channel (active_i=0): count_i holds; enable_i is ignored.
- Event counter, on each expiry:
  - evt_i increments.
  - At all-ones it holds if EVT_WRAP=0, or goes to 0 if EVT_WRAP=1.
- evt_clear_i:
  - Alone: evt_i <= 0.
  - In the same cycle as an expiry: evt_i <= 1, so the event is counted.
- Channel independence: channels share only load_value. Simultaneous loads on several channels all take the same value.
- Outputs are registered; count_out and evt_out reflect register contents directly.

Test Plan:
- Reset/idle: resetn low mid-count with count_out=37, plus idle checks:
  - Outputs go to 0 immediately, without a clk edge.
  - After release with no load, expire stays 0 for 100 cycles.
- Periodic: load ch0 with 5, periodic=1, enable=1, held 20 cycles:
  - expire[0] pulses 4 times, 5 cycles apart.
  - count_out sequence 5,4,3,2,1,5,...
  - evt_out[0] = 4.
- One-shot and zero load, ch1 loaded with 3, periodic=0:
  - Exactly one pulse, 3 edges after the load edge; then active[1]=0 and count=0.
  - Reloading with 0 keeps active[1]=0 and produces no pulse.
- Pause: load 10, enable low from count 6 for 50 cycles:
  - count holds at 6 and no pulse occurs.
  - After re-enable, a pulse arrives 6 cycles later.
- Event counter boundaries (EVT_W=8):
  - EVT_WRAP=0: evt saturates at 255 after 300 expiries.
  - EVT_WRAP=1: evt reads 44 after 300 expiries.
  - evt_clear coincident with an expiry gives evt=1.
- Load collision: load asserted on the cycle count==1:
  - No expire pulse; count becomes load_value.
  - Two channels loaded simultaneously both show the same count.
